// File: rtl/logic_unit_if.sv
// Operand/result handshake bundle for logic_unit_pipe.
// master = producer/consumer side, slave = the logic unit itself.
interface logic_unit_if #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [2:0]       in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_zero;
    logic             out_par;
    logic [CNT_W-1:0] op_count;

    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_data, out_zero, out_par, op_count
    );

    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_data, out_zero, out_par, op_count
    );
endinterface

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined bitwise logic unit with valid/ready backpressure and a result counter.
// Optional result flags (out_zero, out_par) are built only when LOGIC_FLAGS_EN is defined.
module logic_unit_pipe #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input logic        clk,
    input logic        rst_n,
    logic_unit_if.slave bus
);
    typedef enum logic [2:0] {
        OP_NAND = 3'd0,
        OP_AND  = 3'd1,
        OP_OR   = 3'd2,
        OP_NOR  = 3'd3,
        OP_XOR  = 3'd4,
        OP_XNOR = 3'd5,
        OP_NOTA = 3'd6,
        OP_PASS = 3'd7
    } op_e;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             s1_valid;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;
    op_e              s1_op;
    logic             s2_valid;
    logic [WIDTH-1:0] s2_data;
    logic [WIDTH-1:0] f_res;
    logic [CNT_W-1:0] count;
    logic             adv2;
    logic             in_rdy;
    logic             in_fire;
    logic             out_fire;

    // Stage 1 may accept whenever it is empty or its occupant moves on this cycle.
    assign adv2     = !s2_valid || bus.out_ready;
    assign in_rdy   = !s1_valid || adv2;
    assign in_fire  = bus.in_valid && in_rdy;
    assign out_fire = s2_valid && bus.out_ready;

    assign bus.in_ready  = in_rdy;
    assign bus.out_valid = s2_valid;
    assign bus.out_data  = s2_data;
    assign bus.op_count  = count;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
        end else if (in_rdy) begin
            s1_valid <= bus.in_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            s1_a  <= bus.in_a;
            s1_b  <= bus.in_b;
            s1_op <= op_e'(bus.in_op);
        end
    end

    always_comb begin
        f_res = '0;
        case (s1_op)
            OP_NAND: f_res = ~(s1_a & s1_b);
            OP_AND:  f_res =   s1_a & s1_b;
            OP_OR:   f_res =   s1_a | s1_b;
            OP_NOR:  f_res = ~(s1_a | s1_b);
            OP_XOR:  f_res =   s1_a ^ s1_b;
            OP_XNOR: f_res = ~(s1_a ^ s1_b);
            OP_NOTA: f_res = ~s1_a;
            OP_PASS: f_res =  s1_a;
            default: f_res = '0;
        endcase
    end

    // out_data is only rewritten by a valid stage-1 entry, so it holds after a drain.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_valid <= 1'b0;
            s2_data  <= '0;
        end else if (adv2) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_data <= f_res;
            end
        end
    end

`ifdef LOGIC_FLAGS_EN
    logic s2_zero;
    logic s2_par;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s2_zero <= 1'b0;
            s2_par  <= 1'b0;
        end else if (adv2 && s1_valid) begin
            s2_zero <= ~|f_res;
            s2_par  <= ^f_res;
        end
    end

    assign bus.out_zero = s2_zero;
    assign bus.out_par  = s2_par;
`else
    assign bus.out_zero = 1'b0;
    assign bus.out_par  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count <= '0;
        end else if (out_fire) begin
            count <= count + CNT_ONE;
        end
    end
endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe with a result scoreboard; honours LOGIC_FLAGS_EN.
module tb_logic_unit_pipe;
    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    // Per-op truth table indexed by {a_bit, b_bit}.
    localparam logic [3:0] TT [8] = '{4'b0111, 4'b1000, 4'b1110, 4'b0001,
                                      4'b0110, 4'b1001, 4'b0011, 4'b1100};

    logic clk = 1'b0;
    logic rst_n;
    int   n_chk  = 0;
    int   n_fail = 0;
    int   n_out  = 0;
    logic [W+1:0] sbq[$];

    logic_unit_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    logic_unit_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic [2:0] op);
        logic [3:0]   t;
        logic [W-1:0] r;
        t = TT[op];
        for (int i = 0; i < int'(W); i++) r[i] = t[{a[i], b[i]}];
        return r;
    endfunction

    function automatic logic [W+1:0] expect_all(input logic [W-1:0] d);
        logic z;
        logic p;
        z = 1'b0;
        p = 1'b0;
`ifdef LOGIC_FLAGS_EN
        z = (d == '0);
        for (int i = 0; i < int'(W); i++) p = p ^ d[i];
`endif
        return {p, z, d};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            sbq.delete();
        end else begin
            if (bus.out_valid && bus.out_ready) begin
                n_out++;
                if (sbq.size() == 0) check("sb_underflow", 32'd1, 32'd0);
                else check("sb_result", {bus.out_par, bus.out_zero, bus.out_data}, sbq.pop_front());
            end
            if (bus.in_valid && bus.in_ready)
                sbq.push_back(expect_all(model(bus.in_a, bus.in_b, bus.in_op)));
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [2:0] op);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = op;
    endtask

    task automatic drain();
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20 && sbq.size() != 0; i++) step();
        check("drain_timeout", sbq.size(), 32'd0);
    endtask

    initial begin
        logic [W-1:0] tt1 [8];
        logic [W-1:0] ra;
        int           base;
        tt1 = '{8'h3F, 8'hC0, 8'hFC, 8'h03, 8'h3C, 8'hC3, 8'h0F, 8'hF0};

        rst_n = 1'b0;
        bus.in_valid = 1'b0; bus.in_a = '0; bus.in_b = '0; bus.in_op = '0;
        bus.out_ready = 1'b1;
        step(); step();
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_data", bus.out_data, 0);
        check("rst_flags", {bus.out_zero, bus.out_par}, 0);
        check("rst_op_count", bus.op_count, 0);
        rst_n = 1'b1;
        step();
        check("rst_in_ready", bus.in_ready, 1);

        // Truth table, back-to-back, result two cycles after transfer
        for (int k = 0; k < 8; k++) begin
            drive(8'hF0, 8'hCC, 3'(k));
            step();
            if (k == 0) check("tt_latency", bus.out_valid, 0);
            else check("tt_data", {bus.out_valid, bus.out_data}, {1'b1, tt1[k-1]});
        end
        bus.in_valid = 1'b0;
        step();
        check("tt_data_last", {bus.out_valid, bus.out_data}, {1'b1, tt1[7]});
        step();
        check("tt_empty", bus.out_valid, 0);
        check("tt_op_count", bus.op_count, 8);

        // Backpressure
        base = n_out;
        bus.out_ready = 1'b0;
        drive(8'h12, 8'h34, 3'd1); step();
        drive(8'h5A, 8'h0F, 3'd4); step();
        drive(8'h77, 8'h11, 3'd3);
        #1;
        check("bp_in_ready_low", bus.in_ready, 0);
        check("bp_out_data", {bus.out_valid, bus.out_data}, {1'b1, model(8'h12, 8'h34, 3'd1)});
        step(); step(); step();
        check("bp_hold_ready", bus.in_ready, 0);
        check("bp_hold_data", bus.out_data, model(8'h12, 8'h34, 3'd1));
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", bus.in_ready, 1);
        step();
        drain();
        check("bp_delivered", n_out - base, 3);

        // Reset with two transactions in flight
        bus.out_ready = 1'b0;
        drive(8'hA5, 8'h3C, 3'd0); step();
        drive(8'h0F, 8'hF0, 3'd2); step();
        bus.in_valid = 1'b0;
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        check("rf_out_valid", bus.out_valid, 0);
        check("rf_op_count", bus.op_count, 0);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("rf_no_output", bus.out_valid, 0);
        end

        // Counter wrap: 17 transfers into a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            drive(8'($urandom), 8'($urandom), 3'($urandom_range(7)));
            step();
        end
        drain();
        check("wrap_op_count", bus.op_count, 1);

        // Flags
        drive(8'hAA, 8'h55, 3'd1); step();
        bus.in_valid = 1'b0; step();
        check("flag_and_data", bus.out_data, 8'h00);
`ifdef LOGIC_FLAGS_EN
        check("flag_and", {bus.out_zero, bus.out_par}, 2'b10);
`else
        check("flag_and_off", {bus.out_zero, bus.out_par}, 2'b00);
`endif
        drive(8'h01, 8'h00, 3'd4); step();
        bus.in_valid = 1'b0; step();
        check("flag_xor_data", bus.out_data, 8'h01);
`ifdef LOGIC_FLAGS_EN
        check("flag_xor", {bus.out_zero, bus.out_par}, 2'b01);
`else
        check("flag_xor_off", {bus.out_zero, bus.out_par}, 2'b00);
`endif
        step();
        check("drain_hold_data", {bus.out_valid, bus.out_data}, {1'b0, 8'h01});

        // Continuous input with toggling out_ready
        bus.out_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            ra = 8'($urandom);
            drive(ra, 8'($urandom), 3'($urandom_range(7)));
            step();
        end
        for (int i = 0; i < 8; i++) begin
            bus.out_ready = (i % 2 == 0);
            ra = 8'($urandom);
            drive(ra, 8'($urandom), 3'($urandom_range(7)));
            #1;
            check("sim_in_ready", bus.in_ready, bus.out_ready);
            step();
        end
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
